// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter.
// The optional watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

    localparam int C_NB_REQ         = 2;
    localparam int C_DATA_WIDTH     = 8;
    localparam int C_GAP_CYCLES     = 4;
    localparam int C_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SEND,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: the search starts just after last_grant
// and wraps, so the most recently served requester has lowest priority.
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int G_NB_REQ = C_NB_REQ
)(
    input  logic [G_NB_REQ-1:0]        req,
    input  logic [idx_w(G_NB_REQ)-1:0] last_grant,
    output logic [G_NB_REQ-1:0]        grant
);

    localparam int IW = idx_w(G_NB_REQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = last_grant;
        for (int i = 0; i < G_NB_REQ; i++) begin
            idx = (idx == IW'(G_NB_REQ - 1)) ? '0 : idx + IW'(1);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter feeding one UART TX core from G_NB_REQ
// requesters. rst_n is active-high. Define UART_TX_ARB_TIMEOUT_EN for the
// WAIT_DONE watchdog and its o_timeout_err port.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int G_NB_REQ         = C_NB_REQ,
    parameter int G_DATA_WIDTH     = C_DATA_WIDTH,
    parameter int G_GAP_CYCLES     = C_GAP_CYCLES,
    parameter int G_TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [G_NB_REQ-1:0]              i_req,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data,
    input  logic [G_NB_REQ-1:0]              i_last,
    output logic [G_NB_REQ-1:0]              o_ack,
    output logic [G_NB_REQ-1:0]              o_grant,
    output logic                             o_tx_start,
    output logic [G_DATA_WIDTH-1:0]          o_tx_data,
    input  logic                             i_tx_done,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output logic                             o_timeout_err,
`endif
    output logic                             o_busy
);

    localparam int IW      = idx_w(G_NB_REQ);
    localparam int CNT_MAX = (G_TIMEOUT_CYCLES > G_GAP_CYCLES) ? G_TIMEOUT_CYCLES : G_GAP_CYCLES;
    localparam int CW      = cnt_w(CNT_MAX);

    state_t                                 state, state_nx, post_frame;
    logic [G_NB_REQ-1:0]                    arb_grant, grant_q;
    logic [IW-1:0]                          arb_idx, grant_idx_q, last_grant_q, sel_idx;
    logic [G_NB_REQ-1:0][G_DATA_WIDTH-1:0]  data_arr;
    logic [G_DATA_WIDTH-1:0]                tx_data_q;
    logic                                   last_q, abort_q, frame_end, gap_end;
    logic [CW-1:0]                          cnt;

    assign data_arr = i_data;

    rr_arbiter #(.G_NB_REQ(G_NB_REQ)) u_rr (
        .req        (i_req),
        .last_grant (last_grant_q),
        .grant      (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < G_NB_REQ; k++)
            if (arb_grant[k]) arb_idx = IW'(k);
    end

    // The byte loaded on entry to SEND comes from the new winner out of ARB,
    // otherwise from the owner of the frame in progress.
    assign sel_idx   = (state == ST_ARB) ? arb_idx : grant_idx_q;
    assign frame_end = last_q | abort_q | ~i_req[grant_idx_q];
    assign gap_end   = (cnt == CW'(G_GAP_CYCLES - 1));
    assign post_frame = (G_GAP_CYCLES == 0) ? ((|i_req) ? ST_ARB : ST_IDLE) : ST_GAP;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic wd_end, timeout_q;
    assign wd_end = (cnt == CW'(G_TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (|i_req) state_nx = ST_ARB;
            ST_ARB:       state_nx = (|arb_grant) ? ST_SEND : ST_IDLE;
            ST_SEND:      state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_tx_done) state_nx = frame_end ? post_frame : ST_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (wd_end) state_nx = post_frame;
`endif
            end
            ST_GAP:       if (gap_end) state_nx = (|i_req) ? ST_ARB : ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_grant    = '0;
        o_ack      = '0;
        o_tx_start = 1'b0;
        o_busy     = (state != ST_IDLE);
        case (state)
            ST_ARB:       o_grant = arb_grant;
            ST_SEND: begin
                o_grant    = grant_q;
                o_ack      = grant_q;
                o_tx_start = 1'b1;
            end
            ST_WAIT_DONE: o_grant = grant_q;
            default:      o_grant = '0;
        endcase
    end

    assign o_tx_data = tx_data_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            grant_q      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IW'(G_NB_REQ - 1);
            tx_data_q    <= '0;
            last_q       <= 1'b0;
            abort_q      <= 1'b0;
            cnt          <= '0;
        end else begin
            if (state == ST_ARB && state_nx == ST_SEND) begin
                grant_q      <= arb_grant;
                grant_idx_q  <= arb_idx;
                last_grant_q <= arb_idx;
            end
            if (state_nx == ST_SEND) begin
                tx_data_q <= data_arr[sel_idx];
                last_q    <= i_last[sel_idx];
            end
            // A dropped request is remembered so a late re-raise cannot revive the frame.
            if (state == ST_ARB)
                abort_q <= 1'b0;
            else if (state == ST_WAIT_DONE && !i_req[grant_idx_q])
                abort_q <= 1'b1;
            // One counter serves both GAP timing and the WAIT_DONE watchdog.
            if (state_nx != state)
                cnt <= '0;
            else if (state == ST_GAP || state == ST_WAIT_DONE)
                cnt <= cnt + CW'(1);
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            timeout_q <= 1'b0;
        else if (state == ST_WAIT_DONE && !i_tx_done && wd_end)
            timeout_q <= 1'b1;
    end

    assign o_timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and TX-core models drive
// the DUT, a monitor pops expected bytes on every o_tx_start.
module tb_uart_tx_arbiter;

    localparam int NB = 2;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NB-1:0]   i_req, i_last, o_ack, o_grant;
    logic [NB*DW-1:0] i_data;
    logic            o_tx_start, i_tx_done, o_busy;
    logic [DW-1:0]   o_tx_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic            o_timeout_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // requester frame store: stimulus writes, model reads and acks
    logic [DW-1:0] rq_data [NB][32];
    logic          rq_last [NB][32];
    int rq_wr [NB] = '{default: 0};
    int rq_rd [NB] = '{default: 0};
    int drop_after [NB] = '{default: 0};
    int frame_acks [NB] = '{default: 0};
    int ack_cnt [NB] = '{default: 0};

    // expected transfers
    int            exp_req   [64];
    logic [DW-1:0] exp_data  [64];
    logic          exp_chain [64];
    int exp_wr = 0;
    int exp_rd = 0;

    int   done_cnt = 0;
    int   done_cyc = 0;
    int   start_cyc = 0;
    int   gap_cnt = 0;
    int   tx_lat = 10;
    logic tx_en = 1'b1;
    logic spur_done = 1'b0;

    uart_tx_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_done  (i_tx_done),
`ifdef UART_TX_ARB_TIMEOUT_EN
        .o_timeout_err (o_timeout_err),
`endif
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // requester model
    always @(negedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (rst_n) begin
                rq_rd[k] = rq_wr[k];
                frame_acks[k] = 0;
            end else if (o_ack[k]) begin
                ack_cnt[k]++;
                frame_acks[k]++;
                if (rq_last[k][rq_rd[k]]) frame_acks[k] = 0;
                rq_rd[k]++;
                if (drop_after[k] != 0 && frame_acks[k] == drop_after[k]) begin
                    rq_rd[k] = rq_wr[k];
                    frame_acks[k] = 0;
                end
            end
            i_req[k] = (rq_rd[k] < rq_wr[k]);
            i_data[k*DW +: DW] = i_req[k] ? rq_data[k][rq_rd[k]] : '0;
            i_last[k] = i_req[k] && rq_last[k][rq_rd[k]];
        end
    end

    // TX core model: done pulse tx_lat cycles after each start
    always @(negedge clk) begin
        i_tx_done = spur_done;
        if (rst_n) done_cnt = 0;
        else begin
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    i_tx_done = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (o_tx_start && tx_en) done_cnt = tx_lat;
        end
    end

    always @(negedge clk)
        if (!rst_n && o_busy && o_grant == '0) gap_cnt++;

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) exp_rd = exp_wr;
        else if (o_tx_start) begin
            start_cyc = cyc;
            if (exp_rd == exp_wr) begin
                checks++; errors++;
                $display("FAIL unexpected_start: data=%h grant=%b, no transfer expected", o_tx_data, o_grant);
            end else begin
                checks++;
                if (o_tx_data !== exp_data[exp_rd]) begin
                    errors++;
                    $display("FAIL tx_data[%0d]: got %h expected %h", exp_rd, o_tx_data, exp_data[exp_rd]);
                end
                checks++;
                if (o_ack !== NB'(1 << exp_req[exp_rd])) begin
                    errors++;
                    $display("FAIL ack[%0d]: got %b expected requester %0d", exp_rd, o_ack, exp_req[exp_rd]);
                end
                checks++;
                if (o_grant !== NB'(1 << exp_req[exp_rd])) begin
                    errors++;
                    $display("FAIL grant[%0d]: got %b expected requester %0d", exp_rd, o_grant, exp_req[exp_rd]);
                end
                if (exp_chain[exp_rd]) begin
                    checks++;
                    if (cyc - done_cyc != 1) begin
                        errors++;
                        $display("FAIL byte_latency[%0d]: got %0d cycles expected 1", exp_rd, cyc - done_cyc);
                    end
                end
                exp_rd++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_byte(input int k, input logic [7:0] d, input logic last);
        rq_data[k][rq_wr[k]] = d;
        rq_last[k][rq_wr[k]] = last;
        rq_wr[k]++;
    endtask

    task automatic expect_tx(input int k, input logic [7:0] d, input logic chained);
        exp_req[exp_wr]   = k;
        exp_data[exp_wr]  = d;
        exp_chain[exp_wr] = chained;
        exp_wr++;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int  n = 0;
        bit  fin = 0;
        while (!fin && n < maxc) begin
            @(negedge clk); #3; n++;
            fin = (exp_rd == exp_wr) && !o_busy && (rq_rd[0] == rq_wr[0]) && (rq_rd[1] == rq_wr[1]);
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, maxc);
        end
    endtask

    initial begin
        int g0, a0, a1, n;

        // reset state
        repeat (2) @(negedge clk); #3;
        chk("rst_ack", 32'(o_ack), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_start", 32'(o_tx_start), 0);
        chk("rst_data", 32'(o_tx_data), 0);
        chk("rst_busy", 32'(o_busy), 0);
        #2 rst_n = 1'b0;

        // single 3-byte frame from requester 0
        g0 = gap_cnt; a0 = ack_cnt[0];
        add_byte(0, 8'hA5, 0); add_byte(0, 8'h5A, 0); add_byte(0, 8'hFF, 1);
        expect_tx(0, 8'hA5, 0); expect_tx(0, 8'h5A, 1); expect_tx(0, 8'hFF, 1);
        wait_idle("t037_idle", 200);
        chk("t037_acks", 32'(ack_cnt[0] - a0), 3);
        chk("t037_gap", 32'(gap_cnt - g0), 4);

        // spurious done while idle
        @(negedge clk); #2 spur_done = 1'b1;
        @(negedge clk); #2 spur_done = 1'b0;
        repeat (3) @(negedge clk); #3;
        chk("spur_busy", 32'(o_busy), 0);
        chk("spur_grant", 32'(o_grant), 0);

        // simultaneous requests, frames not interleaved
        do_reset();
        a0 = ack_cnt[0]; a1 = ack_cnt[1];
        add_byte(0, 8'h11, 0); add_byte(0, 8'h22, 1);
        add_byte(1, 8'h33, 0); add_byte(1, 8'h44, 1);
        expect_tx(0, 8'h11, 0); expect_tx(0, 8'h22, 1);
        expect_tx(1, 8'h33, 0); expect_tx(1, 8'h44, 1);
        wait_idle("t038_idle", 300);
        chk("t038_acks0", 32'(ack_cnt[0] - a0), 2);
        chk("t038_acks1", 32'(ack_cnt[1] - a1), 2);

        // continuous requests alternate 0,1,0,1
        do_reset();
        g0 = gap_cnt;
        add_byte(0, 8'h61, 1); add_byte(0, 8'h63, 1);
        add_byte(1, 8'h62, 1); add_byte(1, 8'h64, 1);
        expect_tx(0, 8'h61, 0); expect_tx(1, 8'h62, 0);
        expect_tx(0, 8'h63, 0); expect_tx(1, 8'h64, 0);
        wait_idle("t039_idle", 300);
        chk("t039_gap", 32'(gap_cnt - g0), 16);

        // request dropped after first byte aborts the frame
        do_reset();
        g0 = gap_cnt; a0 = ack_cnt[0];
        drop_after[0] = 1;
        add_byte(0, 8'hB1, 0); add_byte(0, 8'hB2, 0); add_byte(0, 8'hB3, 1);
        expect_tx(0, 8'hB1, 0);
        wait_idle("t040_idle", 200);
        chk("t040_acks", 32'(ack_cnt[0] - a0), 1);
        chk("t040_gap", 32'(gap_cnt - g0), 4);
        drop_after[0] = 0;

        // reset during WAIT_DONE, then requester 0 wins first
        do_reset();
        add_byte(0, 8'hC1, 0); add_byte(0, 8'hC2, 1);
        expect_tx(0, 8'hC1, 0);
        n = 0;
        while (!o_tx_start && n < 20) begin @(negedge clk); #3; n++; end
        chk("t041_started", 32'(o_tx_start), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("t041_busy", 32'(o_busy), 0);
        chk("t041_grant", 32'(o_grant), 0);
        chk("t041_ack", 32'(o_ack), 0);
        chk("t041_start", 32'(o_tx_start), 0);
        chk("t041_data", 32'(o_tx_data), 0);
        @(negedge clk); #2 rst_n = 1'b0;
        add_byte(0, 8'hD1, 1); add_byte(1, 8'hD2, 1);
        expect_tx(0, 8'hD1, 0); expect_tx(1, 8'hD2, 0);
        wait_idle("t041_idle", 200);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // watchdog: no done, error after 4096 WAIT_DONE cycles
        do_reset();
        tx_en = 1'b0;
        add_byte(0, 8'h77, 1);
        expect_tx(0, 8'h77, 0);
        n = 0;
        while (!o_timeout_err && n < 5000) begin @(negedge clk); #3; n++; end
        chk("to_err", 32'(o_timeout_err), 1);
        chk("to_delay", 32'(cyc - start_cyc), 4097);
        chk("to_gap_busy", 32'(o_busy), 1);
        chk("to_gap_grant", 32'(o_grant), 0);
        tx_en = 1'b1;
        add_byte(0, 8'h88, 1);
        expect_tx(0, 8'h88, 0);
        wait_idle("to_next_idle", 200);
        chk("to_sticky", 32'(o_timeout_err), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter G_NB_REQ, default 2, number of requesters sharing one UART checker TX channel.
REQ-002 Parameter G_DATA_WIDTH, default 8, byte width per transfer.
REQ-003 Parameter G_GAP_CYCLES, default 4, idle clk cycles forced between frames.
REQ-004 Parameter G_TIMEOUT_CYCLES, default 4096, i_tx_done watchdog limit; used only with the timeout feature.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-high.
REQ-007 i_req  input  G_NB_REQ  per-requester frame request, held high until its last byte is acked.
REQ-008 i_data  input  G_NB_REQ*G_DATA_WIDTH  per-requester current byte, slice k = requester k.
REQ-009 i_last  input  G_NB_REQ  per-requester flag marking the current byte as the frame's last.
REQ-010 o_ack  output  G_NB_REQ  one-cycle pulse, byte of requester k consumed.
REQ-011 o_grant  output  G_NB_REQ  one-hot owner of the TX channel, zero when idle.
REQ-012 o_tx_start  output  1  one-cycle start pulse to the UART TX core.
REQ-013 o_tx_data  output  G_DATA_WIDTH  byte to transmit, valid with o_tx_start and held until i_tx_done.
REQ-014 i_tx_done  input  1  one-cycle pulse from the UART TX core, byte fully shifted out.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_timeout_err  output  1  sticky watchdog error; present only with the timeout feature.

Function
REQ-017 FSM states: IDLE, ARB, SEND, WAIT_DONE, GAP.
REQ-018 IDLE -> ARB when any i_req bit is high; otherwise stay in IDLE.
REQ-019 ARB: round-robin pick, search starts at (last_grant+1) mod G_NB_REQ; set o_grant one-hot; go to SEND in the next cycle.
REQ-020 SEND: capture i_data of the granted requester into o_tx_data; pulse o_tx_start and o_ack[grant] in the same cycle; go to WAIT_DONE.
REQ-021 WAIT_DONE: on i_tx_done, go to SEND if the captured byte was not last; go to GAP if it was last.
REQ-022 Byte-to-byte latency: next o_tx_start exactly 1 cycle after i_tx_done within a frame.
REQ-023 GAP: clear o_grant; count G_GAP_CYCLES cycles; then go to ARB if any i_req is high, else IDLE; G_GAP_CYCLES=0 skips GAP.
REQ-024 Grant is frame-atomic; other requests never preempt an in-progress frame.
REQ-025 Granted i_req dropping before its last byte aborts the frame: finish the pending WAIT_DONE, then go to GAP, with no further o_ack.
REQ-026 i_tx_done outside WAIT_DONE is ignored.
REQ-027 last_grant pointer wraps from G_NB_REQ-1 to 0.
REQ-028 Single active requester is re-granted back-to-back, separated only by GAP.

Reset
REQ-029 rst_n high asynchronously forces IDLE and clears o_ack, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout_err, the gap counter and the watchdog counter.
REQ-030 Reset sets last_grant to G_NB_REQ-1 so that requester 0 has first priority.
REQ-031 Reset mid-frame drops the frame and produces no o_ack or o_tx_start in the release cycle.

Configuration
REQ-032 Macro UART_TX_ARB_TIMEOUT_EN enables the WAIT_DONE watchdog.
REQ-033 With the macro: G_TIMEOUT_CYCLES cycles in WAIT_DONE without i_tx_done sets o_timeout_err (sticky until reset) and forces GAP, aborting the frame.
REQ-034 Without the macro: port o_timeout_err is absent and WAIT_DONE waits indefinitely.

Structure
REQ-035 Package uart_tx_arb_pkg holds the FSM state enum and the default parameter constants.
REQ-036 Round-robin selection lives in sub-module rr_arbiter: inputs req and last_grant, output one-hot grant, combinational.

Verification
REQ-037 Reset then i_req=01 with 3 bytes 0xA5,0x5A,0xFF (last on 0xFF), TX done 10 cycles after each start -> 3 o_tx_start with those bytes, 3 o_ack[0], then GAP of 4 cycles, then IDLE.
REQ-038 i_req=11 asserted together, 2-byte frames each -> requester 0 frame completes first, then requester 1, with no interleaving.
REQ-039 i_req=11 held continuously -> grant alternates 0,1,0,1 across 4 frames.
REQ-040 i_req[0] dropped after 1 of 3 bytes -> current byte completes, no further o_ack, frame aborted to GAP.
REQ-041 rst_n asserted during WAIT_DONE -> all outputs 0 the same cycle; after release requester 0 is granted first.
REQ-042 UART_TX_ARB_TIMEOUT_EN defined, i_tx_done never pulsed -> o_timeout_err=1 after 4096 cycles, FSM in GAP, next frame is serviced.
